// File: rtl/timer_pkg.sv
// Shared constants and types for the APB-mapped 8-bit timer.
package timer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_TDR  = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_TCR  = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_TSR  = 8'h02;
  localparam logic [ADDR_W-1:0] ADDR_TCNT = 8'h03;

  localparam int unsigned TCR_LOAD = 7;
  localparam int unsigned TCR_DIR  = 5;
  localparam int unsigned TCR_EN   = 4;
  localparam logic [DATA_W-1:0] TCR_MASK = 8'hB3;

  localparam int unsigned TSR_OVF = 0;
  localparam int unsigned TSR_UDF = 1;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_READY  = 2'd3
  } apb_state_e;

  // Prescaler bits that must all be ones for a tick at the given divide ratio.
  function automatic logic [3:0] cks_mask(input cks_e cks);
    case (cks)
      CKS_DIV2:  cks_mask = 4'b0001;
      CKS_DIV4:  cks_mask = 4'b0011;
      CKS_DIV8:  cks_mask = 4'b0111;
      default:   cks_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/timer_apb_slave_core.sv
// Prescaler, up/down TCNT and sticky overflow/underflow flags.
module timer_core
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tdr,
  input  logic              load,
  input  logic              en,
  input  logic              dir,
  input  cks_e              cks,
  input  logic              clr_ovf,
  input  logic              clr_udf,
  output logic [DATA_W-1:0] tcnt,
  output logic              ovf,
  output logic              udf
);

  logic [3:0] pre;
  logic       tick;
  logic       step;
  logic       set_ovf;
  logic       set_udf;

  assign tick    = (pre & cks_mask(cks)) == cks_mask(cks);
  assign step    = en & ~load & tick;
  assign set_ovf = step & ~dir & (tcnt == 8'hFF);
  assign set_udf = step &  dir & (tcnt == 8'h00);

  // A flag set in the same cycle as a W0C clear must survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre  <= '0;
      tcnt <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      pre <= (en & ~load) ? pre + 4'd1 : 4'd0;
      if (load) begin
        tcnt <= tdr;
      end else if (step) begin
        tcnt <= dir ? tcnt - 8'd1 : tcnt + 8'd1;
      end
      ovf <= set_ovf | (ovf & ~clr_ovf);
      udf <= set_udf | (udf & ~clr_udf);
    end
  end

endmodule

// File: rtl/timer_apb_slave.sv
// APB responder for the 8-bit timer: transfer FSM and TDR/TCR/TSR/TCNT decode.
module timer_apb_slave
  import timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
)(
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              tmr_ovf,
  output logic              tmr_udf
);

  localparam logic [1:0] WS = 2'(WAIT_STATES);

  apb_state_e        state;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] tdr;
  logic [DATA_W-1:0] tcr;
  logic [DATA_W-1:0] tcnt;
  logic              ovf;
  logic              udf;
  logic [DATA_W-1:0] rd_mux;
  logic              addr_err;
  logic              err;
  logic              done;
  logic              wr_ok;
  logic              clr_ovf;
  logic              clr_udf;

  // Last wait cycle of the access; the transfer completes on this edge.
  assign done = psel & (((state == APB_SETUP) & (WS == 2'd0)) |
                        ((state == APB_ACCESS) & (wait_cnt == WS)));

  always_comb begin
    rd_mux   = '0;
    addr_err = 1'b0;
    case (paddr)
      ADDR_TDR:  rd_mux = tdr;
      ADDR_TCR:  rd_mux = tcr;
      ADDR_TSR:  rd_mux = {6'd0, udf, ovf};
      ADDR_TCNT: rd_mux = tcnt;
      default:   addr_err = 1'b1;
    endcase
  end

  assign err     = addr_err | (pwrite & (paddr == ADDR_TCNT));
  assign wr_ok   = done & pwrite & ~err;
  assign clr_ovf = wr_ok & (paddr == ADDR_TSR) & ~pwdata[TSR_OVF];
  assign clr_udf = wr_ok & (paddr == ADDR_TSR) & ~pwdata[TSR_UDF];

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= APB_IDLE;
      wait_cnt <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      tdr      <= '0;
      tcr      <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      case (state)
        APB_IDLE: begin
          if (psel && !penable) state <= APB_SETUP;
        end
        APB_SETUP, APB_ACCESS: begin
          if (!psel) begin
            state <= APB_IDLE;
          end else if (done) begin
            state   <= APB_READY;
            pready  <= 1'b1;
            pslverr <= err;
            prdata  <= rd_mux;
          end else begin
            state    <= APB_ACCESS;
            wait_cnt <= (state == APB_SETUP) ? 2'd1 : wait_cnt + 2'd1;
          end
        end
        APB_READY: begin
          state <= (psel && !penable) ? APB_SETUP : APB_IDLE;
        end
        default: state <= APB_IDLE;
      endcase
      if (wr_ok && (paddr == ADDR_TDR)) tdr <= pwdata;
      if (wr_ok && (paddr == ADDR_TCR)) tcr <= pwdata & TCR_MASK;
    end
  end

  timer_core u_core (
    .clk     (pclk),
    .rst     (preset),
    .tdr     (tdr),
    .load    (tcr[TCR_LOAD]),
    .en      (tcr[TCR_EN]),
    .dir     (tcr[TCR_DIR]),
    .cks     (cks_e'(tcr[1:0])),
    .clr_ovf (clr_ovf),
    .clr_udf (clr_udf),
    .tcnt    (tcnt),
    .ovf     (ovf),
    .udf     (udf)
  );

  assign tmr_ovf = ovf;
  assign tmr_udf = udf;

endmodule
